// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch / load-store memory port arbiter.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_WAIT  = 3'd1,
    LD_WAIT  = 3'd2,
    ST_WAIT  = 3'd3,
    IF_DRAIN = 3'd4
  } arb_state_e;

  // Uncached, unmapped window of the virtual address space.
  localparam logic [2:0] KSEG1 = 3'b101;

  // Virtual-to-physical translation: strip the segment bits and flag kseg1 as
  // uncached. Returns {phys[31:0], cached}.
  function automatic logic [32:0] addr_xlate(input logic [31:0] vaddr);
    return {3'b000, vaddr[28:0], (vaddr[31:29] != KSEG1)};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port between the arbiter (master) and the AXI bridge (slave).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_ren;
  logic              mem_wen;
  logic [3:0]        mem_wsel;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_cached;
  logic [ADDR_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_bvalid;

  modport master (
    output mem_ren, mem_wen, mem_wsel, mem_addr, mem_wdata, mem_cached,
    input  mem_rdata, mem_rvalid, mem_bvalid
  );

  modport slave (
    input  mem_ren, mem_wen, mem_wsel, mem_addr, mem_wdata, mem_cached,
    output mem_rdata, mem_rvalid, mem_bvalid
  );
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       at_limit
);

  // Clear wins over increment; increment stops at 15.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != 4'hF)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt >= 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and load/store. Data has priority; the starvation counter forces a
// fetch through after STARVE_LIMIT data grants; flush kills a fetch in flight.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_data,
  input  logic              ls_ren,
  input  logic              ls_wen,
  input  logic [3:0]        ls_wsel,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [ADDR_W-1:0] ls_wdata,
  output logic              ls_rvalid,
  output logic [ADDR_W-1:0] ls_rdata,
  output logic              ls_bvalid,
  mem_port_arbiter_if.master mem
);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_IF_WAIT  = IF_WAIT;
  localparam logic [2:0] S_LD_WAIT  = LD_WAIT;
  localparam logic [2:0] S_ST_WAIT  = ST_WAIT;
  localparam logic [2:0] S_IF_DRAIN = IF_DRAIN;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              data_req;
  logic              grant_data;
  logic              grant_fetch;
  logic              at_limit;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [32:0]       xl;

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] wdata_r;
  logic [3:0]        wsel_r;
  logic              cached_r;

  assign data_req = ls_ren | ls_wen;

  // Arbitration in IDLE: data first unless the fetch side has been starved.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state == S_IDLE) begin
      if (data_req && !at_limit) begin
        grant_data = 1'b1;
      end else if (if_req && !flush) begin
        grant_fetch = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end
    end
  end

  assign sel_addr = grant_fetch ? if_addr : ls_addr;
  assign xl       = addr_xlate(32'(sel_addr));

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (grant_data && if_req),
    .clr      (grant_fetch || ((state == S_IDLE) && !if_req)),
    .cnt      (starve_cnt),
    .at_limit (at_limit)
  );

  // Next-state logic; a flushed fetch must still drain its response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_data) begin
          state_nxt = ls_wen ? S_ST_WAIT : S_LD_WAIT;
        end else if (grant_fetch) begin
          state_nxt = S_IF_WAIT;
        end
      end
      S_IF_WAIT: begin
        if (mem.mem_rvalid) begin
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_IF_DRAIN;
        end
      end
      S_LD_WAIT:  if (mem.mem_rvalid) state_nxt = S_IDLE;
      S_ST_WAIT:  if (mem.mem_bvalid) state_nxt = S_IDLE;
      S_IF_DRAIN: if (mem.mem_rvalid) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture on grant; the reset value is the translation of address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r   <= '0;
      wdata_r  <= '0;
      wsel_r   <= 4'd0;
      cached_r <= 1'b1;
    end else if (grant_data || grant_fetch) begin
      addr_r   <= ADDR_W'(xl[32:1]);
      cached_r <= xl[0];
      wsel_r   <= grant_data ? ls_wsel : 4'd0;
      wdata_r  <= grant_data ? ls_wdata : '0;
    end
  end

  assign mem.mem_ren    = (state == S_IF_WAIT) || (state == S_LD_WAIT) ||
                          (state == S_IF_DRAIN);
  assign mem.mem_wen    = (state == S_ST_WAIT);
  assign mem.mem_addr   = addr_r;
  assign mem.mem_wdata  = wdata_r;
  assign mem.mem_wsel   = wsel_r;
  assign mem.mem_cached = cached_r;

  assign if_valid  = (state == S_IF_WAIT) && mem.mem_rvalid && !flush;
  assign ls_rvalid = (state == S_LD_WAIT) && mem.mem_rvalid;
  assign ls_bvalid = (state == S_ST_WAIT) && mem.mem_bvalid;
  assign if_data   = mem.mem_rdata;
  assign ls_rdata  = mem.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-outstanding arbiter that shares one memory port between the core's instruction-fetch channel and its load/store channel. It sits between the core and the AXI bridge. It latches one request at a time, issues it on the shared port, and routes the read data or write acknowledge back to the requester that owns it. Data requests have priority; a starvation counter guarantees fetch progress, and a pipeline flush discards an in-flight fetch response.

## Interface
Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants after which a pending fetch wins the next arbitration (1..15).
- ADDR_W, 32, address and data width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; kills any pending or in-flight fetch.
- if_req  in  1  fetch request, level-held until if_valid or flush.
- if_addr  in  ADDR_W  fetch PC (virtual).
- if_valid  out  1  fetch data valid, one-cycle pulse.
- if_data  out  ADDR_W  fetched instruction.
- ls_ren  in  1  load request, level-held until ls_rvalid.
- ls_wen  in  1  store request, level-held until ls_bvalid (ls_ren and ls_wen are never both set).
- ls_wsel  in  4  store byte strobes.
- ls_addr  in  ADDR_W  load/store virtual address.
- ls_wdata  in  ADDR_W  store data.
- ls_rvalid  out  1  load data valid pulse.
- ls_rdata  out  ADDR_W  load data.
- ls_bvalid  out  1  store complete pulse.
- mem_ren, mem_wen  out  1  port read and write enables, held until the response arrives.
- mem_wsel  out  4  port byte strobes.
- mem_addr  out  ADDR_W  physical address: {3'b0, addr[28:0]}.
- mem_wdata  out  ADDR_W  port write data.
- mem_cached  out  1  0 when the virtual addr[31:29] == 3'b101 (kseg1), otherwise 1.
- mem_rdata  in  ADDR_W  port read data.
- mem_rvalid, mem_bvalid  in  1  port read and write response pulses.

## Operation
- States:
  - IDLE.
  - IF_WAIT.
  - LD_WAIT.
  - ST_WAIT.
  - IF_DRAIN: fetch was killed; the arbiter is still waiting for its response.
- IDLE arbitration:
  - If a data request is present and starve_cnt < STARVE_LIMIT, grant data.
  - Otherwise, if if_req && !flush, grant fetch.
  - Otherwise, if only a data request is present, grant data.
- On grant, the arbiter latches addr, wsel, wdata and the translated cached bit into registers. The next state is LD_WAIT, ST_WAIT or IF_WAIT.
- starve_cnt (4 bits):
  - Increments on every data grant made while if_req is high, saturating at 15.
  - Clears on a fetch grant, and whenever if_req is low in IDLE.
- WAIT states:
  - mem_* are driven from the latched registers; mem_ren or mem_wen is high for the whole state.
  - On mem_rvalid (LD/IF) or mem_bvalid (ST), the matching *_valid pulses combinationally in the same cycle and the next state is IDLE.
- Flush during IF_WAIT:
  - If mem_rvalid arrives in the same cycle, if_valid is suppressed and the next state is IDLE.
  - Otherwise the next state is IF_DRAIN, and mem_ren stays high.
- IF_DRAIN: the next mem_rvalid is consumed with no if_valid, and the next state is IDLE.
- Flush does not affect LD_WAIT or ST_WAIT; data transactions always complete.
- Responses that do not match the current state (e.g. mem_bvalid in IF_WAIT) are ignored.
- if_data and ls_rdata are wired directly from mem_rdata; they are meaningful only while the matching valid is high.

## Timing
- Reset values:
  - state = IDLE, starve_cnt = 0, all latched registers 0.
  - All mem_* outputs are 0, except mem_cached = 1.
  - All *_valid outputs are 0.
- Request seen in IDLE at cycle 0: mem_ren or mem_wen is high from cycle 1.
- Response at cycle N: the requester's valid is high at cycle N (zero added latency), and the arbiter is back in IDLE at N+1.
- Minimum turnaround is 2 cycles, so back-to-back grants are at least 2 cycles apart.
- Requesters must drop or update their request in the cycle after their valid. A still-high request in IDLE is treated as a new request.
- Reset mid-transaction: the arbiter returns to IDLE next cycle. A late response arriving in IDLE is ignored.

## Structure
- Shared package arb_pkg holds:
  - The state enum (IDLE, IF_WAIT, LD_WAIT, ST_WAIT, IF_DRAIN).
  - The KSEG1 constant 3'b101.
  - An addr_xlate function returning {phys, cached}.
- One sub-module, arb_starve_counter, implements the saturating counter with inc/clr inputs and a limit-reached output. Everything else is one FSM module.

## Test plan
- Fetch only: if_req=1, if_addr=0xBFC00000, mem_rvalid at cycle 3 with 0x3C080001.
  - mem_ren=1 from cycle 1, mem_addr=0x1FC00000, mem_cached=0.
  - if_valid=1 at cycle 3 with if_data=0x3C080001.
- Simultaneous fetch and store: ls_wen=1, ls_addr=0x80001000, wsel=0xF, wdata=0xDEADBEEF, with if_req=1.
  - The store is granted first, with mem_cached=1 and mem_addr=0x00001000.
  - After the ls_bvalid pulse, the fetch is granted.
- Starvation, STARVE_LIMIT=4: if_req held high, loads requested continuously.
  - Exactly 4 load grants occur, then a fetch grant, then starve_cnt=0.
- Flush in IF_WAIT at cycle 2, mem_rvalid at cycle 5.
  - The arbiter is in IF_DRAIN at cycles 3-5, if_valid never pulses, and it is in IDLE at cycle 6.
- Flush in LD_WAIT: ls_rvalid still pulses with mem_rdata.
- Flush coincident with mem_rvalid in IF_WAIT: if_valid stays 0, and the state is IDLE the next cycle.
- Reset asserted during ST_WAIT:
  - All outputs return to reset values next cycle.
  - A later stray mem_bvalid produces no ls_bvalid.
